// File: rtl/axi_dc_dst_isolate_pkg.sv
// rtl/axi_dc_dst_isolate_pkg.sv - AXI channel and bundle types shared by the dst isolation slice
package axi_dc_dst_isolate_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } axi_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    axi_b_t  b;
    logic    b_valid;
    axi_r_t  r;
    logic    r_valid;
  } axi_resp_t;

endpackage

// File: rtl/axi_dc_iso_cnt.sv
// rtl/axi_dc_iso_cnt.sv - outstanding-burst up/down counter with zero, full and next-empty flags
module axi_dc_iso_cnt #(
  parameter int unsigned MaxTxn = 8,
  parameter int unsigned CntW   = $clog2(MaxTxn + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            dec,
  output logic [CntW-1:0] cnt,
  output logic            zero,
  output logic            full,
  output logic            drained
);

  logic [CntW-1:0] cnt_d;

  // Simultaneous increment and decrement cancel out
  always_comb begin
    cnt_d = cnt;
    if (inc && !dec) begin
      cnt_d = cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

  assign zero    = (cnt == '0);
  assign full    = (cnt == CntW'(MaxTxn));
  // Empty after this cycle's handshakes settle; lets the drain finish one cycle earlier
  assign drained = (cnt_d == '0);

endmodule

// File: rtl/axi_dc_dst_isolate.sv
// rtl/axi_dc_dst_isolate.sv - drains and gates the dst side of the AXI CDC before freezing it
module axi_dc_dst_isolate
  import axi_dc_dst_isolate_pkg::*;
#(
  parameter int unsigned MaxTxn = 8,
  parameter type         req_t  = axi_req_t,
  parameter type         resp_t = axi_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  isolate_req_i,
  output logic  isolated_o,
  output logic  isolate_o,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o,
  input  resp_t mst_resp_i
);

  localparam int unsigned CntW = $clog2(MaxTxn + 1);

  localparam logic [1:0] StNormal   = 2'd0;
  localparam logic [1:0] StDrain    = 2'd1;
  localparam logic [1:0] StIsolated = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            isolated_q;
  logic [CntW-1:0] wr_cnt, w_cnt, rd_cnt;
  logic            wr_zero, w_zero, rd_zero;
  logic            wr_full, w_full, rd_full;
  logic            wr_drained, w_drained, rd_drained;
  logic            aw_open, ar_open, w_open;
  logic            aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

  // New bursts only start in NORMAL and while the tracking counter has room
  assign aw_open = (state_q == StNormal) && !wr_full;
  assign ar_open = (state_q == StNormal) && !rd_full;
  assign aw_hs   = slv_req_i.aw_valid && aw_open && mst_resp_i.aw_ready;
  assign ar_hs   = slv_req_i.ar_valid && ar_open && mst_resp_i.ar_ready;
  // W may lead its AW on the slave port; hold it until the burst is accounted for
  assign w_open    = !w_zero || aw_hs;
  assign w_last_hs = slv_req_i.w_valid && w_open && mst_resp_i.w_ready && slv_req_i.w.last;
  assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

  // Payloads pass straight through; only handshake qualifiers are gated
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid && aw_open;
    mst_req_o.ar_valid = slv_req_i.ar_valid && ar_open;
    mst_req_o.w_valid  = slv_req_i.w_valid && w_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready && w_open;
  end

  axi_dc_iso_cnt #(.MaxTxn(MaxTxn), .CntW(CntW)) u_wr_cnt (
    .clk(clk_i), .rst_n(rst_ni), .inc(aw_hs), .dec(b_hs),
    .cnt(wr_cnt), .zero(wr_zero), .full(wr_full), .drained(wr_drained)
  );

  axi_dc_iso_cnt #(.MaxTxn(MaxTxn), .CntW(CntW)) u_w_cnt (
    .clk(clk_i), .rst_n(rst_ni), .inc(aw_hs), .dec(w_last_hs),
    .cnt(w_cnt), .zero(w_zero), .full(w_full), .drained(w_drained)
  );

  axi_dc_iso_cnt #(.MaxTxn(MaxTxn), .CntW(CntW)) u_rd_cnt (
    .clk(clk_i), .rst_n(rst_ni), .inc(ar_hs), .dec(r_last_hs),
    .cnt(rd_cnt), .zero(rd_zero), .full(rd_full), .drained(rd_drained)
  );

  // Request enters drain; drain completes once every direction is empty, a dropped request aborts
  always_comb begin
    state_d = state_q;
    case (state_q)
      StNormal:   if (isolate_req_i) state_d = StDrain;
      StDrain: begin
        if (!isolate_req_i) begin
          state_d = StNormal;
        end else if (wr_drained && w_drained && rd_drained) begin
          state_d = StIsolated;
        end
      end
      StIsolated: if (!isolate_req_i) state_d = StNormal;
      default:    state_d = StNormal;
    endcase
  end

  // State and registered isolation flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StNormal;
      isolated_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      isolated_q <= (state_d == StIsolated);
    end
  end

  assign isolated_o = isolated_q;
  assign isolate_o  = isolated_q;

  // Upstream protocol violations the controller does not recover from
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_hs && wr_zero));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_last_hs && rd_zero));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(aw_hs && wr_full && !b_hs));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(aw_hs && w_full && !w_last_hs));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(ar_hs && rd_full && !r_last_hs));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (w_cnt <= wr_cnt) && (rd_cnt <= CntW'(MaxTxn)));

endmodule

// File: tb/tb_axi_dc_dst_isolate.sv
// tb/tb_axi_dc_dst_isolate.sv - directed self-checking bench for the dst isolation controller
module tb_axi_dc_dst_isolate;
  import axi_dc_dst_isolate_pkg::*;

  logic      clk;
  logic      rst_n;
  logic [1:0] iso_req;
  logic [1:0] isolated;
  logic [1:0] isolate;
  axi_req_t  sreq  [2];
  axi_resp_t sresp [2];
  axi_req_t  mreq  [2];
  axi_resp_t mresp [2];

  int n_checks = 0;
  int n_fail   = 0;

  axi_dc_dst_isolate #(.MaxTxn(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .isolate_req_i(iso_req[0]),
    .isolated_o(isolated[0]), .isolate_o(isolate[0]),
    .slv_req_i(sreq[0]), .slv_resp_o(sresp[0]),
    .mst_req_o(mreq[0]), .mst_resp_i(mresp[0])
  );

  axi_dc_dst_isolate #(.MaxTxn(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .isolate_req_i(iso_req[1]),
    .isolated_o(isolated[1]), .isolate_o(isolate[1]),
    .slv_req_i(sreq[1]), .slv_resp_o(sresp[1]),
    .mst_req_o(mreq[1]), .mst_resp_i(mresp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    iso_req = 2'b00;
    sreq[0] = '0; sreq[1] = '0; mresp[0] = '0; mresp[1] = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_isolated",  32'(isolated[0]), 32'd0);
    check("rst_isolate",   32'(isolate[0]),  32'd0);
    check("rst_isolated2", 32'(isolated[1]), 32'd0);
    sreq[0].aw.addr = 32'h0000_1234;
    sreq[0].aw_valid = 1'b1;
    #1;
    check("pass_aw_addr",  mreq[0].aw.addr, 32'h0000_1234);
    check("pass_aw_valid", 32'(mreq[0].aw_valid), 32'd1);
    sreq[0].aw_valid = 1'b0;

    // Idle isolation: isolated two cycles after request
    tick();
    iso_req[0] = 1'b1;
    mresp[0].aw_ready = 1'b1; mresp[0].ar_ready = 1'b1;
    #1;
    check("t1_awrdy_req_cycle", 32'(sresp[0].aw_ready), 32'd1);
    tick();
    sreq[0].aw_valid = 1'b1;
    #1;
    check("t1_iso_c1",   32'(isolated[0]), 32'd0);
    check("t1_awrdy_c1", 32'(sresp[0].aw_ready), 32'd0);
    check("t1_arrdy_c1", 32'(sresp[0].ar_ready), 32'd0);
    check("t1_awvld_c1", 32'(mreq[0].aw_valid), 32'd0);
    tick();
    sreq[0].w_valid = 1'b1; mresp[0].w_ready = 1'b1;
    #1;
    check("t1_iso_c2",     32'(isolated[0]), 32'd1);
    check("t1_isolate_c2", 32'(isolate[0]),  32'd1);
    check("t1_wvld_iso",   32'(mreq[0].w_valid), 32'd0);
    check("t1_wrdy_iso",   32'(sresp[0].w_ready), 32'd0);
    sreq[0] = '0;
    iso_req[0] = 1'b0;
    tick();
    #1;
    check("t1_iso_release",  32'(isolated[0]), 32'd0);
    check("t1_aw_reopen",    32'(sresp[0].aw_ready), 32'd1);

    // Three AW bursts of 4 beats, then drain W and B
    sreq[0].aw.len = 8'd3;
    sreq[0].aw_valid = 1'b1;
    tick(); tick(); tick();
    sreq[0].aw_valid = 1'b0;
    iso_req[0] = 1'b1;
    tick();
    sreq[0].aw_valid = 1'b1;
    #1;
    check("t2_aw_blocked", 32'(sresp[0].aw_ready), 32'd0);
    sreq[0].aw_valid = 1'b0;
    for (int b = 0; b < 12; b++) begin
      sreq[0].w_valid = 1'b1;
      sreq[0].w.data  = 32'(b);
      sreq[0].w.last  = (b % 4 == 3);
      #1;
      check($sformatf("t2_w_pass_%0d", b), 32'(mreq[0].w_valid && sresp[0].w_ready), 32'd1);
      tick();
    end
    sreq[0].w_valid = 1'b0;
    sreq[0].w.last  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      mresp[0].b_valid = 1'b1;
      sreq[0].b_ready  = 1'b1;
      #1;
      check($sformatf("t2_iso_before_b%0d", j), 32'(isolated[0]), 32'd0);
      check($sformatf("t2_bvld_pass_%0d", j), 32'(sresp[0].b_valid), 32'd1);
      tick();
    end
    mresp[0].b_valid = 1'b0;
    sreq[0].b_ready  = 1'b0;
    #1;
    check("t2_iso_after_b", 32'(isolated[0]), 32'd1);
    iso_req[0] = 1'b0;
    tick();

    // One 8-beat read in flight, isolate, new AR held
    sreq[0].ar.len = 8'd7;
    sreq[0].ar_valid = 1'b1;
    tick();
    sreq[0].ar_valid = 1'b0;
    iso_req[0] = 1'b1;
    tick();
    sreq[0].ar_valid = 1'b1;
    sreq[0].r_ready  = 1'b1;
    for (int b = 0; b < 8; b++) begin
      mresp[0].r_valid = 1'b1;
      mresp[0].r.data  = 32'h100 + 32'(b);
      mresp[0].r.last  = (b == 7);
      #1;
      check($sformatf("t3_iso_before_r%0d", b), 32'(isolated[0]), 32'd0);
      check($sformatf("t3_ar_held_%0d", b), 32'(sresp[0].ar_ready || mreq[0].ar_valid), 32'd0);
      tick();
    end
    check("t3_rdata_pass", sresp[0].r.data, 32'h107);
    mresp[0].r_valid = 1'b0;
    mresp[0].r.last  = 1'b0;
    sreq[0].r_ready  = 1'b0;
    #1;
    check("t3_iso_after_r", 32'(isolated[0]), 32'd1);
    check("t3_ar_held_iso", 32'(sresp[0].ar_ready), 32'd0);
    sreq[0].ar_valid = 1'b0;
    iso_req[0] = 1'b0;
    tick();

    // MaxTxn=2: third AW blocked; AW and B in the same cycle cancel
    sreq[1].aw_valid = 1'b1; sreq[1].w_valid = 1'b1; sreq[1].w.last = 1'b1;
    mresp[1].aw_ready = 1'b1; mresp[1].w_ready = 1'b1;
    #1;
    check("t4_aw1_rdy", 32'(sresp[1].aw_ready), 32'd1);
    check("t4_w1_rdy",  32'(sresp[1].w_ready),  32'd1);
    tick();
    check("t4_aw2_rdy", 32'(sresp[1].aw_ready), 32'd1);
    tick();
    check("t4_aw3_blocked", 32'(sresp[1].aw_ready), 32'd0);
    check("t4_aw3_vld",     32'(mreq[1].aw_valid),  32'd0);
    check("t4_w3_stalled",  32'(sresp[1].w_ready),  32'd0);
    check("t4_wr_cnt_full", 32'(u_dut2.wr_cnt), 32'd2);
    mresp[1].b_valid = 1'b1; sreq[1].b_ready = 1'b1;
    #1;
    check("t4_aw_blocked_with_b", 32'(sresp[1].aw_ready), 32'd0);
    tick();
    check("t4_wr_cnt_after_b", 32'(u_dut2.wr_cnt), 32'd1);
    check("t4_aw_reopen",      32'(sresp[1].aw_ready), 32'd1);
    tick();
    check("t4_wr_cnt_aw_b", 32'(u_dut2.wr_cnt), 32'd1);
    mresp[1].b_valid = 1'b0; sreq[1].b_ready = 1'b0;
    tick();
    check("t4_wr_cnt_refill", 32'(u_dut2.wr_cnt), 32'd2);
    check("t4_aw_blocked_again", 32'(sresp[1].aw_ready), 32'd0);
    sreq[1] = '0; mresp[1] = '0;

    // W two cycles ahead of its AW
    sreq[0].w_valid = 1'b1; sreq[0].w.last = 1'b1; sreq[0].w.data = 32'hA5A5;
    mresp[0].w_ready = 1'b1; mresp[0].aw_ready = 1'b1;
    sreq[0].aw.len = 8'd0;
    #1;
    check("t5_w_early0_rdy", 32'(sresp[0].w_ready), 32'd0);
    check("t5_w_early0_vld", 32'(mreq[0].w_valid),  32'd0);
    tick();
    check("t5_w_early1_rdy", 32'(sresp[0].w_ready), 32'd0);
    tick();
    sreq[0].aw_valid = 1'b1;
    #1;
    check("t5_w_with_aw_rdy", 32'(sresp[0].w_ready), 32'd1);
    check("t5_w_with_aw_vld", 32'(mreq[0].w_valid),  32'd1);
    check("t5_w_data",        mreq[0].w.data, 32'hA5A5);
    tick();
    sreq[0].aw_valid = 1'b0; sreq[0].w_valid = 1'b0; sreq[0].w.last = 1'b0;
    #1;
    check("t5_w_cnt", 32'(u_dut8.w_cnt),  32'd0);
    check("t5_wr_cnt", 32'(u_dut8.wr_cnt), 32'd1);
    mresp[0].b_valid = 1'b1; sreq[0].b_ready = 1'b1;
    tick();
    mresp[0].b_valid = 1'b0; sreq[0].b_ready = 1'b0;

    // Abort drain with one write outstanding, then reset mid-burst
    sreq[0].aw_valid = 1'b1;
    tick();
    sreq[0].aw_valid = 1'b0;
    iso_req[0] = 1'b1;
    tick();
    #1;
    check("t6_drain_aw_closed", 32'(sresp[0].aw_ready), 32'd0);
    tick();
    check("t6_drain_iso0", 32'(isolated[0]), 32'd0);
    iso_req[0] = 1'b0;
    tick();
    check("t6_abort_aw_open", 32'(sresp[0].aw_ready), 32'd1);
    check("t6_abort_iso0",    32'(isolated[0]), 32'd0);
    check("t6_wr_cnt_kept",   32'(u_dut8.wr_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr_cnt",  32'(u_dut8.wr_cnt), 32'd0);
    check("t6_rst_w_cnt",   32'(u_dut8.w_cnt),  32'd0);
    check("t6_rst_rd_cnt",  32'(u_dut8.rd_cnt), 32'd0);
    check("t6_rst_wr_cnt2", 32'(u_dut2.wr_cnt), 32'd0);
    check("t6_rst_iso",     32'(isolated[0]),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
